// File: rtl/count_sched_pkg.sv
// Shared types and constants for the count_sched burst scheduler.
//   sched_state_t : scheduler FSM states (IDLE, RUN, DONE)
//   CH0 / CH1     : channel select encodings driven onto Slt
//   LEN_W_DEF     : default burst-length / remaining-count width
//   STAT_W_DEF    : default completed-burst counter width
package count_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    localparam int unsigned LEN_W_DEF  = 8;
    localparam int unsigned STAT_W_DEF = 16;

endpackage

// File: rtl/count_sched_rr_arb2.sv
// rr_arb2: purely combinational 2-input round-robin picker.
// Ports:
//   req       in  [1:0] request vector (bit n = channel n)
//   ptr       in        channel that wins when both request
//   gnt_valid out       at least one request present
//   gnt_idx   out       index of the winning channel
module rr_arb2
    import count_sched_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    // A lone requester always wins; a tie goes to the pointer.
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = CH0;
        if (req == 2'b11) begin
            gnt_idx = ptr;
        end else if (req[1]) begin
            gnt_idx = CH1;
        end
    end

endmodule

// File: rtl/count_sched.sv
// count_sched: two-channel round-robin burst scheduler driving En/Slt of the
// dual up-counter datapath for exactly the granted burst length.
// Ports:
//   Clk, Reset      clock (rising edge), asynchronous active-high reset
//   Req0/Len0       channel-0 request (held until Ack0) and burst length
//   Req1/Len1       channel-1 request (held until Ack1) and burst length
//   Pause           stalls enable issue and the remaining count while in RUN
//   Ack0/Ack1       one-cycle completion pulse per channel
//   En/Slt          count enable and channel select to the datapath
//   Busy            high whenever the scheduler is not IDLE
//   Bursts0/Bursts1 per-channel completed-burst counters, present only when
//                   COUNT_SCHED_STAT_EN is defined
// All outputs are registered.
module count_sched
    import count_sched_pkg::*;
#(
    parameter int unsigned LEN_W  = LEN_W_DEF
`ifdef COUNT_SCHED_STAT_EN
  , parameter int unsigned STAT_W = STAT_W_DEF
`endif
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Req0,
    input  logic [LEN_W-1:0] Len0,
    input  logic             Req1,
    input  logic [LEN_W-1:0] Len1,
    input  logic             Pause,
    output logic             Ack0,
    output logic             Ack1,
    output logic             En,
    output logic             Slt,
    output logic             Busy
`ifdef COUNT_SCHED_STAT_EN
  , output logic [STAT_W-1:0] Bursts0,
    output logic [STAT_W-1:0] Bursts1
`endif
);

    sched_state_t     state_q;
    logic             gnt_q;
    logic             rr_ptr_q;
    logic [LEN_W-1:0] rem_q;

    logic             arb_valid;
    logic             arb_idx;
    logic [LEN_W-1:0] arb_len;

    rr_arb2 u_arb (
        .req       ({Req1, Req0}),
        .ptr       (rr_ptr_q),
        .gnt_valid (arb_valid),
        .gnt_idx   (arb_idx)
    );

    // Length of whichever channel the arbiter would grant this cycle.
    assign arb_len = arb_idx ? Len1 : Len0;

    // Scheduler FSM with registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            gnt_q    <= CH0;
            rr_ptr_q <= CH0;
            rem_q    <= '0;
            Ack0     <= 1'b0;
            Ack1     <= 1'b0;
            En       <= 1'b0;
            Slt      <= CH0;
            Busy     <= 1'b0;
        end else begin
            Ack0 <= 1'b0;
            Ack1 <= 1'b0;
            En   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        gnt_q <= arb_idx;
                        Slt   <= arb_idx;
                        rem_q <= arb_len;
                        Busy  <= 1'b1;
                        // A zero-length burst skips RUN and just acknowledges.
                        state_q <= (arb_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (!Pause) begin
                        En    <= 1'b1;
                        rem_q <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (gnt_q == CH0) begin
                        Ack0 <= 1'b1;
                    end else begin
                        Ack1 <= 1'b1;
                    end
                    // The channel just served loses the next tie.
                    rr_ptr_q <= ~gnt_q;
                    Busy     <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    Busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef COUNT_SCHED_STAT_EN
    // Completed-burst counters, bumped in the DONE cycle; wrap naturally.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Bursts0 <= '0;
            Bursts1 <= '0;
        end else if (state_q == DONE) begin
            if (gnt_q == CH0) begin
                Bursts0 <= Bursts0 + STAT_W'(1);
            end else begin
                Bursts1 <= Bursts1 + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_count_sched.sv
// Self-checking bench for count_sched: directed scenarios plus randomized
// request rounds checked against a burst-level arbitration model.
module tb_count_sched;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Req0, Req1, Pause;
    logic [7:0] Len0, Len1;
    logic       Ack0, Ack1, En, Slt, Busy;
`ifdef COUNT_SCHED_STAT_EN
    logic [15:0] Bursts0, Bursts1;
`endif

    int checks = 0;
    int errors = 0;

    count_sched dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Req0  (Req0),
        .Len0  (Len0),
        .Req1  (Req1),
        .Len1  (Len1),
        .Pause (Pause),
        .Ack0  (Ack0),
        .Ack1  (Ack1),
        .En    (En),
        .Slt   (Slt),
        .Busy  (Busy)
`ifdef COUNT_SCHED_STAT_EN
      , .Bursts0 (Bursts0),
        .Bursts1 (Bursts1)
`endif
    );

    always #5 Clk = ~Clk;

    // Advance to the next falling edge; requesters release on their Ack.
    task automatic step();
        @(negedge Clk);
        if (Ack0) Req0 = 1'b0;
        if (Ack1) Req1 = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Req0  = 1'b0;
        Req1  = 1'b0;
        Pause = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Req0 = 1'b0; Req1 = 1'b0; Pause = 1'b0; Len0 = 8'd0; Len1 = 8'd0;
        @(negedge Clk);
        checks++;
        if ({Ack0, Ack1, En, Slt, Busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got {Ack0,Ack1,En,Slt,Busy}=%b want 00000",
                     {Ack0, Ack1, En, Slt, Busy});
        end
        Reset = 1'b0;
    endtask

    task automatic test_single();
        logic exp_en, exp_ack, exp_busy;
        Len0 = 8'd3;
        Req0 = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            exp_en   = (k >= 2 && k <= 4);
            exp_ack  = (k == 5);
            exp_busy = (k <= 4);
            checks++;
            if ({En, Ack0, Ack1, Busy} !== {exp_en, exp_ack, 1'b0, exp_busy}) begin
                errors++;
                $display("FAIL single k=%0d: got {En,Ack0,Ack1,Busy}=%b want %b",
                         k, {En, Ack0, Ack1, Busy}, {exp_en, exp_ack, 1'b0, exp_busy});
            end
            if (En) begin
                checks++;
                if (Slt !== 1'b0) begin
                    errors++;
                    $display("FAIL single_slt k=%0d: got %b want 0", k, Slt);
                end
            end
        end
    endtask

    task automatic test_both();
        logic exp_en, exp_slt, exp_a0, exp_a1;
        do_reset();
        Len0 = 8'd2; Len1 = 8'd4;
        Req0 = 1'b1; Req1 = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            exp_en  = (k == 2 || k == 3 || (k >= 6 && k <= 9));
            exp_slt = (k >= 6);
            exp_a0  = (k == 4);
            exp_a1  = (k == 10);
            checks++;
            if ({En, Ack0, Ack1} !== {exp_en, exp_a0, exp_a1}) begin
                errors++;
                $display("FAIL both k=%0d: got {En,Ack0,Ack1}=%b want %b",
                         k, {En, Ack0, Ack1}, {exp_en, exp_a0, exp_a1});
            end
            if (exp_en) begin
                checks++;
                if (Slt !== exp_slt) begin
                    errors++;
                    $display("FAIL both_slt k=%0d: got %b want %b", k, Slt, exp_slt);
                end
            end
        end
    endtask

    task automatic test_len_zero();
        Len1 = 8'd0;
        Req1 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if ({En, Ack0, Ack1, Busy} !== {1'b0, 1'b0, (k == 2), (k == 1)}) begin
                errors++;
                $display("FAIL len_zero k=%0d: got {En,Ack0,Ack1,Busy}=%b want %b",
                         k, {En, Ack0, Ack1, Busy}, {1'b0, 1'b0, (k == 2), (k == 1)});
            end
        end
    endtask

    task automatic test_pause();
        logic exp_en;
        int   n_en;
        n_en = 0;
        Len0 = 8'd5;
        Req0 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            exp_en = (k == 2 || (k >= 5 && k <= 8));
            if (En) n_en++;
            checks++;
            if ({En, Ack0, Busy} !== {exp_en, (k == 9), (k <= 8)}) begin
                errors++;
                $display("FAIL pause k=%0d: got {En,Ack0,Busy}=%b want %b",
                         k, {En, Ack0, Busy}, {exp_en, (k == 9), (k <= 8)});
            end
            if (k == 2) Pause = 1'b1;
            if (k == 4) Pause = 1'b0;
        end
        checks++;
        if (n_en != 5) begin
            errors++;
            $display("FAIL pause_total: got %0d enables want 5", n_en);
        end
    endtask

    task automatic test_reset_mid();
        int  n_en, n_ack;
        bit  got;
        n_en = 0;
        Len0 = 8'd10;
        Req0 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (En) n_en++;
        end
        checks++;
        if (n_en != 4) begin
            errors++;
            $display("FAIL reset_mid_pre: got %0d enables want 4", n_en);
        end
        #1 Reset = 1'b1;
        #1;
        checks++;
        if ({En, Busy, Ack0} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_async: got {En,Busy,Ack0}=%b want 000", {En, Busy, Ack0});
        end
        Req0 = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        n_en = 0; n_ack = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (En) n_en++;
            if (Ack0 || Ack1) n_ack++;
        end
        checks++;
        if (n_en != 0 || n_ack != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: got en=%0d ack=%0d want 0 0", n_en, n_ack);
        end
        Len0 = 8'd10;
        Req0 = 1'b1;
        n_en = 0; got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            step();
            if (En) n_en++;
            if (Ack0) got = 1;
        end
        checks++;
        if (!got || n_en != 10) begin
            errors++;
            $display("FAIL reset_mid_rerun: got ack=%0d en=%0d want 1 10", got, n_en);
        end
    endtask

    task automatic test_max_len();
        int n_en;
        bit got;
        n_en = 0; got = 0;
        Len0 = 8'd255;
        Req0 = 1'b1;
        for (int k = 0; k < 400 && !got; k++) begin
            step();
            if (En) n_en++;
            if (Ack0) got = 1;
        end
        checks++;
        if (!got || n_en != 255) begin
            errors++;
            $display("FAIL max_len: got ack=%0d en=%0d want 1 255", got, n_en);
        end
    endtask

`ifdef COUNT_SCHED_STAT_EN
    task automatic run_one(input int ch, input logic [7:0] len);
        bit got;
        got = 0;
        if (ch == 0) begin Len0 = len; Req0 = 1'b1; end
        else         begin Len1 = len; Req1 = 1'b1; end
        for (int k = 0; k < 100 && !got; k++) begin
            step();
            if (Ack0 || Ack1) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL stat_burst_timeout: ch=%0d got no ack want ack", ch);
        end
    endtask

    task automatic test_stats();
        do_reset();
        checks++;
        if (Bursts0 !== 16'd0 || Bursts1 !== 16'd0) begin
            errors++;
            $display("FAIL stat_init: got %0d %0d want 0 0", Bursts0, Bursts1);
        end
        run_one(0, 8'd2); run_one(1, 8'd0); run_one(0, 8'd3);
        run_one(1, 8'd1); run_one(0, 8'd0);
        step();
        checks++;
        if (Bursts0 !== 16'd3 || Bursts1 !== 16'd2) begin
            errors++;
            $display("FAIL stat_count: got %0d %0d want 3 2", Bursts0, Bursts1);
        end
        do_reset();
        checks++;
        if (Bursts0 !== 16'd0 || Bursts1 !== 16'd0) begin
            errors++;
            $display("FAIL stat_reset: got %0d %0d want 0 0", Bursts0, Bursts1);
        end
    endtask
`endif

    // Random rounds: a random non-empty set of requesters with random lengths
    // and random Pause. Model: ties go to the pointer, the pointer flips to
    // the other channel after each completion, each burst yields Len enables.
    task automatic test_random();
        int         ptr_m, cur, en_cnt, budget, pat;
        logic [7:0] lens [2];
        int         order [$];
        logic       prev_pause;
        do_reset();
        ptr_m = 0;
        for (int r = 0; r < 40; r++) begin
            pat     = int'($urandom_range(1, 3));
            lens[0] = 8'($urandom_range(0, 12));
            lens[1] = 8'($urandom_range(0, 12));
            order.delete();
            if (pat == 3) begin
                order.push_back(ptr_m);
                order.push_back(1 - ptr_m);
            end else begin
                order.push_back(pat == 1 ? 0 : 1);
            end
            Len0 = lens[0]; Len1 = lens[1];
            Req0 = pat[0];  Req1 = pat[1];
            en_cnt = 0; budget = 0;
            while (order.size() > 0 && budget < 200) begin
                prev_pause = Pause;
                step();
                budget++;
                cur = order[0];
                if (En) begin
                    en_cnt++;
                    checks++;
                    if (Slt !== cur[0] || prev_pause) begin
                        errors++;
                        $display("FAIL rand_en r=%0d: got Slt=%b pause=%b want Slt=%0d pause=0",
                                 r, Slt, prev_pause, cur);
                    end
                    // Length inputs after grant must be ignored.
                    if (cur == 0) Len0 = 8'($urandom);
                    else          Len1 = 8'($urandom);
                end
                if (Ack0 || Ack1) begin
                    checks++;
                    if ({Ack1, Ack0} !== (cur == 1 ? 2'b10 : 2'b01) || en_cnt != int'(lens[cur])) begin
                        errors++;
                        $display("FAIL rand_ack r=%0d: got {Ack1,Ack0}=%b en=%0d want ch%0d en=%0d",
                                 r, {Ack1, Ack0}, en_cnt, cur, lens[cur]);
                    end
                    ptr_m = 1 - cur;
                    void'(order.pop_front());
                    en_cnt = 0;
                end
                Pause = ($urandom_range(0, 3) == 0);
            end
            checks++;
            if (order.size() != 0 || Busy !== 1'b0) begin
                errors++;
                $display("FAIL rand_round r=%0d: got pending=%0d Busy=%b want 0 0",
                         r, order.size(), Busy);
                do_reset();
                ptr_m = 0;
            end
        end
        Pause = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_both();
        test_len_zero();
        test_pause();
        test_reset_mid();
        test_max_len();
`ifdef COUNT_SCHED_STAT_EN
        test_stats();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
